insr_encoder: RTL and testbench

//  Sequential inverse of the instruction field decoder. Packs MIPS R/I/J fields into 32-bit words.

---
 rtl/insr_encoder_if.sv | 33 +++
 rtl/insr_encoder.sv | 101 ++++++++++
 tb/tb_insr_encoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/insr_encoder_if.sv
// Field-set input stream and packed-word output stream of the MIPS instruction encoder.
// The master side is the loader front end and memory port; the slave side is the encoder.
interface insr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            fmt;
    logic [5:0]            op_code;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [15:0]           imm;
    logic [25:0]           target;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           instruction;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  full;
    logic                  err;

    modport master (
        output in_valid, fmt, op_code, rs, rt, rd, shamt, funct, imm, target, out_ready,
        input  in_ready, out_valid, instruction, addr, full, err
    );

    modport slave (
        input  in_valid, fmt, op_code, rs, rt, rd, shamt, funct, imm, target, out_ready,
        output in_ready, out_valid, instruction, addr, full, err
    );
endinterface

// File: rtl/insr_encoder.sv
// Packs MIPS R/I/J fields into 32-bit words and streams them out with consecutive
// instruction-memory addresses, stopping once the last address has been written.
module insr_encoder #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic           clk,
    input logic           rst_n,
    input logic           clear,
    insr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FULL
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                state;
    state_t                state_next;
    logic [31:0]           instruction_q;
    logic [31:0]           packed_word;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  err_q;
    logic                  out_valid;
    logic                  at_last;
    logic                  accept;
    logic                  word_accept;

    assign out_valid   = (state == HOLD);
    assign at_last     = (addr_q == ADDR_LAST);
    // Accepting while the last address is on the bus would need an address that does not exist.
    assign bus.in_ready = (state != FULL) && (!out_valid || (bus.out_ready && !at_last));
    assign accept      = bus.in_valid && bus.in_ready;
    assign word_accept = accept && (bus.fmt != 2'd3);

    assign bus.out_valid   = out_valid;
    assign bus.instruction = instruction_q;
    assign bus.addr        = addr_q;
    assign bus.full        = (state == FULL);
    assign bus.err         = err_q;

    always_comb begin
        packed_word = '0;
        case (bus.fmt)
            2'd0:    packed_word = {bus.op_code, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            2'd1:    packed_word = {bus.op_code, bus.rs, bus.rt, bus.imm};
            2'd2:    packed_word = {bus.op_code, bus.target};
            default: packed_word = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        if (clear) begin
            state_next = EMPTY;
            addr_next  = BASE_ADDR;
        end else begin
            case (state)
                EMPTY: begin
                    if (word_accept) state_next = HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (at_last) begin
                            state_next = FULL;
                        end else begin
                            addr_next  = addr_q + ADDR_WIDTH'(1);
                            state_next = word_accept ? HOLD : EMPTY;
                        end
                    end
                end
                default: state_next = FULL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            addr_q <= BASE_ADDR;
        end else begin
            state <= state_next;
            addr_q <= addr_next;
        end
    end

    // A reserved format is swallowed without producing a word; it only raises err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_q <= '0;
            err_q         <= 1'b0;
        end else begin
            err_q <= !clear && accept && (bus.fmt == 2'd3);
            if (!clear && word_accept) instruction_q <= packed_word;
        end
    end
endmodule

// File: tb/tb_insr_encoder.sv
// Directed bench for insr_encoder with a 2-bit address so the region fills quickly.
module tb_insr_encoder;
    localparam int AW = 2;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic clear;
    int   errors;
    int   checks;
    vec_t vecs[7];

    insr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    insr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.fmt     = v.fmt;
        bus.op_code = v.op;
        bus.rs      = v.rs;
        bus.rt      = v.rt;
        bus.rd      = v.rd;
        bus.shamt   = v.sh;
        bus.funct   = v.fn;
        bus.imm     = v.imm;
        bus.target  = v.tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic setJ(input logic [25:0] t);
        vec_t v;
        v = '{2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, t, 32'd0};
        applyStimulus(v);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       32'h00221820};
        vecs[1] = '{2'd1, 6'h23, 5'd29, 5'd9,  5'd0,  5'd0,  6'h00, 16'hFFFC, 26'h0,       32'h8FA9FFFC};
        vecs[2] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0100000, 32'h08100000};
        vecs[3] = '{2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h0,       32'h03FFFFFF};
        vecs[4] = '{2'd1, 6'h08, 5'd1,  5'd2,  5'd7,  5'd9,  6'h15, 16'h0005, 26'h3FFFFFF, 32'h20220005};
        vecs[5] = '{2'd2, 6'h3F, 5'd4,  5'd5,  5'd6,  5'd7,  6'h11, 16'hBEEF, 26'h3FFFFFF, 32'hFFFFFFFF};
        vecs[6] = '{2'd1, 6'h00, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 16'hABCD, 26'h0,       32'h0000ABCD};

        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_instr", bus.instruction, 32'd0);
        checkOutput("rst_addr", 32'(bus.addr), 32'd0);
        checkOutput("rst_full", 32'(bus.full), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table: each vector packed in isolation at address 0
        for (int i = 0; i < 7; i++) begin
            doClear();
            bus.out_ready = 1'b0;
            applyStimulus(vecs[i]);
            bus.in_valid = 1'b1;
            checkOutput("tbl_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            checkOutput("tbl_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("tbl_instr", bus.instruction, vecs[i].exp);
            checkOutput("tbl_addr", 32'(bus.addr), 32'd0);
            bus.out_ready = 1'b1;
            tick();
            checkOutput("tbl_drained", 32'(bus.out_valid), 32'd0);
            checkOutput("tbl_addr_inc", 32'(bus.addr), 32'd1);
        end

        // Back-to-back fill of the whole region, then full and clear
        doClear();
        bus.out_ready = 1'b1;
        setJ(26'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("b2b_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("b2b_instr", bus.instruction, 32'h08000000 + 32'(i));
            checkOutput("b2b_addr", 32'(bus.addr), 32'(i));
            if (i < 3) begin
                setJ(26'(i + 1));
                checkOutput("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            end else begin
                checkOutput("last_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end
        tick();
        checkOutput("full_flag", 32'(bus.full), 32'd1);
        checkOutput("full_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("full_addr", 32'(bus.addr), 32'd3);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        checkOutput("full_sticky", 32'(bus.full), 32'd1);
        checkOutput("full_no_word", 32'(bus.out_valid), 32'd0);
        doClear();
        checkOutput("clr_full", 32'(bus.full), 32'd0);
        checkOutput("clr_addr", 32'(bus.addr), 32'd0);
        checkOutput("clr_in_ready", 32'(bus.in_ready), 32'd1);

        // Backpressure: output frozen for 3 cycles, then drains and resumes
        bus.out_ready = 1'b0;
        applyStimulus(vecs[0]);
        bus.in_valid = 1'b1;
        tick();
        applyStimulus(vecs[1]);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_instr", bus.instruction, 32'h00221820);
            checkOutput("stall_addr", 32'(bus.addr), 32'd0);
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("resume_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("resume_instr", bus.instruction, 32'h8FA9FFFC);
        checkOutput("resume_addr", 32'(bus.addr), 32'd1);
        tick();
        checkOutput("resume_empty", 32'(bus.out_valid), 32'd0);
        checkOutput("resume_addr_end", 32'(bus.addr), 32'd2);

        // Reserved format between two words: err pulse, no address gap
        doClear();
        bus.out_ready = 1'b1;
        applyStimulus(vecs[2]);
        bus.in_valid = 1'b1;
        tick();
        checkOutput("rsv_first_addr", 32'(bus.addr), 32'd0);
        checkOutput("rsv_err_low", 32'(bus.err), 32'd0);
        bus.fmt = 2'd3;
        tick();
        checkOutput("rsv_err_pulse", 32'(bus.err), 32'd1);
        checkOutput("rsv_no_word", 32'(bus.out_valid), 32'd0);
        checkOutput("rsv_addr_hold", 32'(bus.addr), 32'd1);
        applyStimulus(vecs[1]);
        tick();
        bus.in_valid = 1'b0;
        checkOutput("rsv_err_end", 32'(bus.err), 32'd0);
        checkOutput("rsv_second_instr", bus.instruction, 32'h8FA9FFFC);
        checkOutput("rsv_second_addr", 32'(bus.addr), 32'd1);
        tick();
        checkOutput("rsv_final_addr", 32'(bus.addr), 32'd2);

        // Clear discards a stalled word
        bus.out_ready = 1'b0;
        applyStimulus(vecs[3]);
        bus.in_valid = 1'b1;
        tick();
        checkOutput("pre_clr_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_clr_addr", 32'(bus.addr), 32'd2);
        doClear();
        checkOutput("clr_drop_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("clr_drop_addr", 32'(bus.addr), 32'd0);

        // Asynchronous reset while a word is stalled
        applyStimulus(vecs[4]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_rst_instr", bus.instruction, 32'd0);
        checkOutput("async_rst_addr", 32'(bus.addr), 32'd0);
        checkOutput("async_rst_full", 32'(bus.full), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_idle", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
